prototype_log2_encoder: RTL and testbench
=========================================

// Module: prototype_log2_encoder
// PURPOSE
//  Upstream feeder for the few-shot bias accumulator. Accepts a prototype vector as a stream of
//  COLS-wide signed beats and converts each element to floor(log2|x|). Drives the accumulator's
//  per-column log2 inputs, its enable and a clear strobe. Signals done once the final beat has
//  been accumulated, so the downstream bias is valid.
// PARAMETERS
//  COLS             16  columns per beat
//  SUB_COLS          4  active columns in 4x4 mode
//  BIT_WIDTH         8  signed element width
//  CHUNK_CNT_WIDTH   6  width of num_chunks; up to 2**CHUNK_CNT_WIDTH beats per prototype
// PORTS
//  clk          in   1                     clock, rising edge
//  rst_n        in   1                     asynchronous reset, active-low
//  start        in   1                     pulse: begin a new prototype
//  in_4x4_mode  in   1                     only columns [0,SUB_COLS) are meaningful
//  num_chunks   in   CHUNK_CNT_WIDTH       beats per prototype minus 1; sampled on start
//  in_valid     in   1                     beat valid
//  in_ready     out  1                     beat accepted when in_valid & in_ready
//  in_data      in   BIT_WIDTH x COLS      signed elements, unpacked array [COLS]
//  out_log2     out  $clog2(BIT_WIDTH) x COLS  registered log2 codes to the accumulator
//  acc_enable   out  1                     accumulator enable, one cycle per beat
//  acc_clear    out  1                     synchronous clear for the accumulator
//  busy         out  1                     high from the cycle after start until done
//  done         out  1                     one-cycle pulse: accumulator holds the full sum
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE. out_log2=0, acc_enable=0, acc_clear=0, busy=0, done=0,
//   in_ready=0, beat counter=0. Taking effect mid-prototype abandons it; no done is produced.
//  FSM states: IDLE, CLEAR, RUN, FLUSH, DONE.
//   IDLE: start=1 -> latch num_chunks, CLEAR. Otherwise stay.
//   CLEAR: acc_clear=1 for exactly one cycle, then RUN.
//   RUN: in_ready=1 (no backpressure). Each accepted beat increments the beat counter.
//    The beat whose count equals the latched num_chunks is the last -> FLUSH.
//   FLUSH: emits acc_enable for the last beat, then DONE.
//   DONE: done=1 for one cycle, then IDLE.
//  start is ignored outside IDLE. in_ready=0 in every state except RUN.
//  Latency: beat accepted at edge t -> out_log2 and acc_enable=1 during cycle t+1.
//   Accumulator updates at edge t+2.
//   done asserts 2 cycles after the last beat is accepted.
//  acc_enable=0 in all cycles without an accepted beat on the previous edge. Bubbles are allowed.
//  Encoding, per column:
//   m = |x|. x = -2**(BIT_WIDTH-1) saturates to 2**(BIT_WIDTH-1)-1.
//   code = index of the MSB set in m. m=0 -> code 0, an accepted approximation
//    (the accumulator adds 4**0=1).
//  In 4x4 mode, codes for columns >= SUB_COLS are forced to 0.
//  out_log2 holds its value when no beat is accepted.
//  busy = state is CLEAR, RUN or FLUSH.
//  num_chunks=0 means a single-beat prototype: CLEAR, RUN(1 beat), FLUSH, DONE.
// STRUCTURE
//  Shared package few_shot_pkg holds the state typedef enum {IDLE,CLEAR,RUN,FLUSH,DONE}
//   and the function log2_code_width(BIT_WIDTH)=$clog2(BIT_WIDTH).
//  One natural sub-module: abs_log2_encoder, a combinational per-element saturating abs plus
//   priority encoder, instantiated COLS times.
//  FSM, beat counter and output register live in the top level.
// TESTING
//  1. Reset asserted mid-RUN (3rd of 5 beats) -> all outputs 0 immediately, state IDLE, no done.
//  2. start with num_chunks=0 and one beat of all 8'sd1 -> acc_clear at cycle 1.
//     acc_enable for one cycle with all codes 0. done 2 cycles after accept.
//  3. Element values 0, 1, 2, 3, 64, 127, -128, -5 -> codes 0, 0, 1, 1, 6, 6, 6, 2.
//  4. 4x4 mode with all elements 8'sd100 -> codes[0:3]=6, codes[4:15]=0.
//     Feeding these to the accumulator gives a sum of 4*4096=16384.
//  5. num_chunks=3 with in_valid toggling 1,0,1,1,0,1 -> exactly 4 acc_enable pulses,
//     each one cycle after its accept. done follows the 4th.
//  6. start pulsed during RUN and in FLUSH -> ignored, beat count unchanged.
//     A start held through IDLE begins exactly one prototype.

Source files
------------

// File: rtl/few_shot_pkg.sv
// few_shot_pkg: shared state encoding and width helper for the few-shot bias datapath
package few_shot_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DONE} state_e;
  function automatic int log2_code_width(input int bit_width);
    return $clog2(bit_width);
  endfunction
endpackage

// File: rtl/prototype_log2_encoder_abs_log2.sv
// abs_log2_encoder: saturating |x| followed by an MSB-index priority encoder
module abs_log2_encoder import few_shot_pkg::*; #(
  parameter int BIT_WIDTH = 8
) (
  input  logic signed [BIT_WIDTH-1:0]                  x,
  output logic [log2_code_width(BIT_WIDTH)-1:0]        code
);
  localparam int CW = log2_code_width(BIT_WIDTH);
  logic [BIT_WIDTH-1:0] m;
  always_comb begin
    m = x[BIT_WIDTH-1] ? ((x == {1'b1, {(BIT_WIDTH-1){1'b0}}}) ? {1'b0, {(BIT_WIDTH-1){1'b1}}} : -x) : x;
    code = '0;
    for (int i = 1; i < BIT_WIDTH; i++)
      if (m[i]) code = i[CW-1:0];
  end
endmodule

// File: rtl/prototype_log2_encoder.sv
// prototype_log2_encoder: streams prototype beats into log2 codes for the bias accumulator
module prototype_log2_encoder import few_shot_pkg::*; #(
  parameter int COLS            = 16,
  parameter int SUB_COLS        = 4,
  parameter int BIT_WIDTH       = 8,
  parameter int CHUNK_CNT_WIDTH = 6
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     in_4x4_mode,
  input  logic [CHUNK_CNT_WIDTH-1:0]               num_chunks,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic signed [BIT_WIDTH-1:0]              in_data [COLS],
  output logic [log2_code_width(BIT_WIDTH)-1:0]    out_log2 [COLS],
  output logic                                     acc_enable,
  output logic                                     acc_clear,
  output logic                                     busy,
  output logic                                     done
);
  localparam int CW = log2_code_width(BIT_WIDTH);
  state_e state, state_nx;
  logic [CHUNK_CNT_WIDTH-1:0] num_q, cnt;
  logic [CW-1:0] raw [COLS];
  logic [CW-1:0] codes [COLS];
  logic accept;
  for (genvar c = 0; c < COLS; c++) begin : g_col
    abs_log2_encoder #(.BIT_WIDTH(BIT_WIDTH)) u_enc (.x(in_data[c]), .code(raw[c]));
    assign codes[c] = (in_4x4_mode && c >= SUB_COLS) ? '0 : raw[c];
  end
  assign accept = in_ready & in_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    acc_clear = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  state_nx = start ? CLEAR : IDLE;
      CLEAR: begin
        acc_clear = 1'b1;
        busy      = 1'b1;
        state_nx  = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        state_nx = (in_valid && cnt == num_q) ? FLUSH : RUN;
      end
      FLUSH: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // codes hold between beats so the accumulator sees stable inputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      num_q      <= '0;
      cnt        <= '0;
      acc_enable <= 1'b0;
      out_log2   <= '{default: '0};
    end else begin
      acc_enable <= accept;
      if (state == IDLE && start) begin
        num_q <= num_chunks;
        cnt   <= '0;
      end
      if (accept) begin
        cnt      <= cnt + 1'b1;
        out_log2 <= codes;
      end
    end
endmodule

// File: tb/tb_prototype_log2_encoder.sv
// tb_prototype_log2_encoder: directed self-checking bench for prototype_log2_encoder
module tb_prototype_log2_encoder;
  localparam int COLS = 16, SUB_COLS = 4, BIT_WIDTH = 8, CCW = 6, CW = 3;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_4x4_mode = 1'b0, in_valid = 1'b0;
  logic [CCW-1:0] num_chunks = '0;
  logic signed [BIT_WIDTH-1:0] in_data [COLS];
  logic [CW-1:0] out_log2 [COLS];
  logic [CW-1:0] exp_codes [COLS];
  logic in_ready, acc_enable, acc_clear, busy, done;
  int total = 0, bad = 0, pulses, clears, sum;
  logic seq [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  always #5 clk = ~clk;
  prototype_log2_encoder #(.COLS(COLS), .SUB_COLS(SUB_COLS), .BIT_WIDTH(BIT_WIDTH), .CHUNK_CNT_WIDTH(CCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_4x4_mode(in_4x4_mode), .num_chunks(num_chunks),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_log2(out_log2),
    .acc_enable(acc_enable), .acc_clear(acc_clear), .busy(busy), .done(done));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic set_all(input logic signed [BIT_WIDTH-1:0] v);
    for (int c = 0; c < COLS; c++) in_data[c] = v;
  endtask
  task automatic check_codes(input string tag);
    for (int c = 0; c < COLS; c++) check($sformatf("%s_col%0d", tag, c), 32'(out_log2[c]), 32'(exp_codes[c]));
  endtask
  task automatic single(input string tag);
    start = 1'b1; num_chunks = '0;
    @(negedge clk); start = 1'b0;
    check({tag, "_clear"}, acc_clear, 1); check({tag, "_busy_clr"}, busy, 1); check({tag, "_rdy_clr"}, in_ready, 0);
    @(negedge clk);
    check({tag, "_rdy_run"}, in_ready, 1); check({tag, "_clear_off"}, acc_clear, 0);
    in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    check({tag, "_en"}, acc_enable, 1); check({tag, "_rdy_flush"}, in_ready, 0);
    check({tag, "_busy_flush"}, busy, 1); check({tag, "_done_early"}, done, 0);
    check_codes(tag);
    @(negedge clk);
    check({tag, "_done"}, done, 1); check({tag, "_en_off"}, acc_enable, 0); check({tag, "_busy_done"}, busy, 0);
    check({tag, "_hold"}, 32'(out_log2[5]), 32'(exp_codes[5]));
    @(negedge clk);
    check({tag, "_done_off"}, done, 0);
  endtask
  initial begin
    set_all('0);
    #12;
    check("rst_busy", busy, 0); check("rst_ready", in_ready, 0); check("rst_en", acc_enable, 0);
    check("rst_clear", acc_clear, 0); check("rst_done", done, 0); check("rst_code", 32'(out_log2[0]), 0);
    @(negedge clk); rst_n = 1'b1;
    // reset in the middle of a five-beat prototype
    start = 1'b1; num_chunks = 6'd4;
    @(negedge clk); start = 1'b0;
    check("t1_clear", acc_clear, 1);
    @(negedge clk);
    set_all(8'sd100); in_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    check("t1_en_pre", acc_enable, 1); check("t1_code_pre", 32'(out_log2[5]), 6);
    #2 rst_n = 1'b0; #1;
    check("t1_en", acc_enable, 0); check("t1_busy", busy, 0); check("t1_ready", in_ready, 0);
    check("t1_clear0", acc_clear, 0); check("t1_done0", done, 0); check("t1_code", 32'(out_log2[5]), 0);
    @(negedge clk); @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("t1_nodone", done, 0); check("t1_idle", busy, 0);
    end
    // element encoding corners
    in_data = '{8'sd0, 8'sd1, 8'sd2, 8'sd3, 8'sd64, 8'sd127, -8'sd128, -8'sd5,
                8'sd4, -8'sd1, -8'sd127, 8'sd32, 8'sd16, 8'sd8, -8'sd64, -8'sd65};
    exp_codes = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd6, 3'd6, 3'd6, 3'd2,
                  3'd2, 3'd0, 3'd6, 3'd5, 3'd4, 3'd3, 3'd6, 3'd6};
    single("t3");
    // single-beat prototype of ones
    set_all(8'sd1);
    exp_codes = '{default: 3'd0};
    single("t2");
    // 4x4 mode masks the upper columns
    in_4x4_mode = 1'b1; set_all(8'sd100);
    for (int c = 0; c < COLS; c++) exp_codes[c] = (c < SUB_COLS) ? 3'd6 : 3'd0;
    single("t4");
    sum = 0;
    for (int c = 0; c < SUB_COLS; c++) sum += 1 << (2 * out_log2[c]);
    check("t4_sum", sum, 16384);
    in_4x4_mode = 1'b0;
    // four beats with bubbles
    set_all(8'sd7);
    start = 1'b1; num_chunks = 6'd3;
    @(negedge clk); start = 1'b0;
    check("t5_clear", acc_clear, 1);
    @(negedge clk);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = seq[i];
      check($sformatf("t5_rdy%0d", i), in_ready, 1);
      @(negedge clk);
      check($sformatf("t5_en%0d", i), acc_enable, 32'(seq[i]));
      check($sformatf("t5_nodone%0d", i), done, 0);
      if (acc_enable) pulses++;
    end
    in_valid = 1'b0;
    check("t5_pulses", pulses, 4); check("t5_code", 32'(out_log2[3]), 2);
    @(negedge clk);
    check("t5_done", done, 1); check("t5_en_off", acc_enable, 0);
    @(negedge clk);
    // start ignored during RUN and FLUSH
    start = 1'b1; num_chunks = 6'd2;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("t6_still_run", in_ready, 1); check("t6_no_done", done, 0);
    @(negedge clk);
    in_valid = 1'b0; start = 1'b1;
    check("t6_flush_rdy", in_ready, 0); check("t6_flush_en", acc_enable, 1); check("t6_flush_done", done, 0);
    @(negedge clk); start = 1'b0;
    check("t6_done", done, 1);
    @(negedge clk);
    check("t6_idle_busy", busy, 0); check("t6_idle_clear", acc_clear, 0); check("t6_idle_done", done, 0);
    // start held across several cycles begins one prototype
    start = 1'b1; num_chunks = '0; clears = 0;
    repeat (3) begin
      @(negedge clk);
      if (acc_clear) clears++;
    end
    start = 1'b0;
    check("t6_clears", clears, 1); check("t6_held_run", in_ready, 1);
    in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    check("t6_held_en", acc_enable, 1);
    @(negedge clk);
    check("t6_held_done", done, 1);
    @(negedge clk);
    check("t6_held_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
